// File: rtl/trigger_pkg.sv
// Shared constants for the ADC trigger engine: FSM state encodings, mode codes
// and default scaling parameters.
package trigger_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_ARMING  = 3'd1;
   localparam state_t ST_READY   = 3'd2;
   localparam state_t ST_CAPTURE = 3'd3;
   localparam state_t ST_HOLDOFF = 3'd4;

   localparam logic [1:0] MODE_NORMAL = 2'd0;
   localparam logic [1:0] MODE_SINGLE = 2'd1;
   localparam logic [1:0] MODE_LEVEL  = 2'd2;

   localparam int DEFAULT_OFFSET = 8000;
   localparam int DEFAULT_GAIN   = 10;

   // Code 3 is reserved and behaves as NORMAL.
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_NORMAL : m;
   endfunction

endpackage

// File: rtl/trig_compare.sv
// Combinational threshold compare: fire/rearm for rising or falling slope,
// with the hysteresis band saturating at 0 and at full scale.
module trig_compare #(
   parameter int DATA_W = 14
) (
   input  logic [DATA_W-1:0] i_adc,
   input  logic [DATA_W-1:0] i_level,
   input  logic [DATA_W-1:0] i_hyst,
   input  logic              i_slope,
   output logic              o_fire,
   output logic              o_rearm
);

   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_hi;
   logic [DATA_W-1:0] w_lo;

   assign w_sum = {1'b0, i_level} + {1'b0, i_hyst};
   assign w_hi  = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
   assign w_lo  = (i_hyst > i_level) ? '0 : i_level - i_hyst;

   assign o_fire  = i_slope ? (i_adc > i_level) : (i_adc < i_level);
   assign o_rearm = i_slope ? (i_adc <= w_lo)   : (i_adc >= w_hi);

endmodule

// File: rtl/trigger_unit.sv
// Trigger engine on the ADC sample stream: edge/level trigger, capture window,
// holdoff and scaled output. Define TRIGGER_TIMESTAMP_EN for trig_timestamp.
module trigger_unit
   import trigger_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int OFFSET = DEFAULT_OFFSET,
   parameter int GAIN   = DEFAULT_GAIN,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_in,
   input  logic              trig_slope,
   input  logic [DATA_W-1:0] trig_level,
   input  logic [DATA_W-1:0] trig_hyst,
   input  logic [1:0]        mode,
   input  logic              arm,
   input  logic [CNT_W-1:0]  post_len,
   input  logic [CNT_W-1:0]  holdoff_len,
   output logic              trigger,
   output logic              capture,
   output logic              busy,
   output logic [DATA_W-1:0] out_pulse,
   output logic              out_valid,
   output logic [31:0]       trig_timestamp
);

   localparam logic [DATA_W-1:0] OFFSET_W = DATA_W'(OFFSET);
   localparam logic [DATA_W-1:0] GAIN_W   = DATA_W'(GAIN);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic              w_fire;
   logic              w_rearm;
   logic [1:0]        w_mode;
   state_t            w_state;
   state_t            w_rest;
   state_t            w_hold_state;
   logic [CNT_W-1:0]  w_hold_cnt;
   logic [CNT_W-1:0]  w_post_rem;
   logic              w_level_mode;
   logic [DATA_W-1:0] w_diff;
   logic [DATA_W-1:0] w_scaled;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_trig;
   logic              w_cap;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_trigger;
   logic              r_capture;
   logic [DATA_W-1:0] r_out_pulse;
   logic              r_out_valid;

   trig_compare #(.DATA_W(DATA_W)) u_cmp (
      .i_adc   (adc_in),
      .i_level (trig_level),
      .i_hyst  (trig_hyst),
      .i_slope (trig_slope),
      .o_fire  (w_fire),
      .o_rearm (w_rearm)
   );

   assign w_mode = norm_mode(mode);

   // IDLE only exists for SINGLE; any other mode behaves as ARMING straight away.
   assign w_state      = (r_state == ST_IDLE && w_mode != MODE_SINGLE) ? ST_ARMING : r_state;
   assign w_level_mode = (w_state == ST_ARMING) && (w_mode == MODE_LEVEL);
   assign w_rest       = (w_mode == MODE_SINGLE) ? ST_IDLE : ST_ARMING;
   assign w_hold_state = (holdoff_len == '0) ? w_rest : ST_HOLDOFF;
   assign w_hold_cnt   = (holdoff_len == '0) ? '0 : holdoff_len;
   assign w_post_rem   = (post_len == '0) ? '0 : post_len - CNT_ONE;

   assign w_diff   = adc_in - OFFSET_W;
   assign w_scaled = w_diff * GAIN_W;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      w_state_nxt = w_state;
      w_cnt_nxt   = r_cnt;
      w_trig      = 1'b0;
      w_cap       = 1'b0;
      case (w_state)
         ST_IDLE: begin
            if (arm) w_state_nxt = ST_ARMING;
         end
         ST_ARMING: begin
            if (adc_valid) begin
               if (w_level_mode) begin
                  w_trig = w_fire;
                  w_cap  = w_fire;
               end else if (w_rearm) begin
                  w_state_nxt = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (adc_valid && w_fire) begin
               w_trig = 1'b1;
               w_cap  = 1'b1;
               if (w_post_rem == '0) begin
                  w_state_nxt = w_hold_state;
                  w_cnt_nxt   = w_hold_cnt;
               end else begin
                  w_state_nxt = ST_CAPTURE;
                  w_cnt_nxt   = w_post_rem;
               end
            end
         end
         ST_CAPTURE: begin
            if (adc_valid) begin
               w_cap = 1'b1;
               if (r_cnt <= CNT_ONE) begin
                  w_state_nxt = w_hold_state;
                  w_cnt_nxt   = w_hold_cnt;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_ONE;
               end
            end
         end
         ST_HOLDOFF: begin
            if (adc_valid) begin
               if (r_cnt <= CNT_ONE) begin
                  w_state_nxt = w_rest;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_ONE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_trigger   <= 1'b0;
         r_capture   <= 1'b0;
         r_out_pulse <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_trigger   <= w_trig;
         r_capture   <= w_cap;
         r_out_pulse <= w_cap ? w_scaled : '0;
         r_out_valid <= adc_valid;
      end
   end

   assign trigger   = r_trigger;
   assign capture   = r_capture;
   assign out_pulse = r_out_pulse;
   assign out_valid = r_out_valid;
   assign busy      = (r_state == ST_CAPTURE) || (r_state == ST_HOLDOFF);

`ifdef TRIGGER_TIMESTAMP_EN
   logic [31:0] r_sample_cnt;
   logic [31:0] r_trig_ts;

   // The counter holds the index of the sample currently on adc_in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sample_cnt <= '0;
         r_trig_ts    <= '0;
      end else begin
         if (adc_valid) r_sample_cnt <= r_sample_cnt + 32'd1;
         if (w_trig)    r_trig_ts    <= r_sample_cnt;
      end
   end

   assign trig_timestamp = r_trig_ts;
`else
   assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_trigger_unit.sv
// Directed self-checking bench for trigger_unit with hand-computed expectations;
// trig_timestamp expectations follow TRIGGER_TIMESTAMP_EN.
module tb_trigger_unit;

   localparam int DATA_W = 14;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              adc_valid = 1'b0;
   logic [DATA_W-1:0] adc_in = '0;
   logic              trig_slope = 1'b1;
   logic [DATA_W-1:0] trig_level = 14'd9000;
   logic [DATA_W-1:0] trig_hyst = 14'd100;
   logic [1:0]        mode = 2'd0;
   logic              arm = 1'b0;
   logic [CNT_W-1:0]  post_len = 16'd4;
   logic [CNT_W-1:0]  holdoff_len = 16'd2;
   logic              trigger;
   logic              capture;
   logic              busy;
   logic [DATA_W-1:0] out_pulse;
   logic              out_valid;
   logic [31:0]       trig_timestamp;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trigger_unit #(
      .DATA_W (DATA_W),
      .OFFSET (8000),
      .GAIN   (10),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .adc_valid      (adc_valid),
      .adc_in         (adc_in),
      .trig_slope     (trig_slope),
      .trig_level     (trig_level),
      .trig_hyst      (trig_hyst),
      .mode           (mode),
      .arm            (arm),
      .post_len       (post_len),
      .holdoff_len    (holdoff_len),
      .trigger        (trigger),
      .capture        (capture),
      .busy           (busy),
      .out_pulse      (out_pulse),
      .out_valid      (out_valid),
      .trig_timestamp (trig_timestamp)
   );

   function automatic logic [31:0] exp_ts(input logic [31:0] idx);
`ifdef TRIGGER_TIMESTAMP_EN
      return idx;
`else
      return (idx == 32'd0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".trig"}, 32'(trigger), 32'd0);
      check({tag, ".cap"},  32'(capture), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".pulse"}, 32'(out_pulse), 32'd0);
      check({tag, ".oval"}, 32'(out_valid), 32'd0);
      check({tag, ".ts"},   trig_timestamp, 32'd0);
   endtask

   // One clock: drive at negedge, sample #1 after the capturing posedge.
   task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] s,
                       input logic e_trig, input logic e_cap, input logic [DATA_W-1:0] e_pulse);
      @(negedge clk);
      adc_valid = v;
      adc_in    = s;
      arm       = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".trig"},  32'(trigger), 32'(e_trig));
      check({tag, ".cap"},   32'(capture), 32'(e_cap));
      check({tag, ".pulse"}, 32'(out_pulse), 32'(e_pulse));
      check({tag, ".oval"},  32'(out_valid), 32'(v));
   endtask

   // Valid sample preceded by two idle clocks (adc_valid every 3rd clk).
   task automatic gstep(input string tag, input logic [DATA_W-1:0] s,
                        input logic e_trig, input logic e_cap, input logic [DATA_W-1:0] e_pulse);
      step({tag, ".gap0"}, 1'b0, 14'd9999, 1'b0, 1'b0, 14'd0);
      step({tag, ".gap1"}, 1'b0, 14'd9999, 1'b0, 1'b0, 14'd0);
      step(tag, 1'b1, s, e_trig, e_cap, e_pulse);
   endtask

   task automatic pulse_arm();
      @(negedge clk);
      adc_valid = 1'b0;
      arm       = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset     = 1'b1;
      adc_valid = 1'b0;
      arm       = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // Rising NORMAL ramp: one trigger at 9050, four captured samples, holdoff 2.
      do_reset("rst0");
      step("r8800", 1'b1, 14'd8800, 1'b0, 1'b0, 14'd0);
      step("r8850", 1'b1, 14'd8850, 1'b0, 1'b0, 14'd0);
      step("r8900", 1'b1, 14'd8900, 1'b0, 1'b0, 14'd0);
      step("r8950", 1'b1, 14'd8950, 1'b0, 1'b0, 14'd0);
      step("r9000", 1'b1, 14'd9000, 1'b0, 1'b0, 14'd0);
      step("r9050", 1'b1, 14'd9050, 1'b1, 1'b1, 14'd10500);
      check("r9050.busy", 32'(busy), 32'd1);
      check("r9050.ts", trig_timestamp, exp_ts(32'd5));
      step("r9100", 1'b1, 14'd9100, 1'b0, 1'b1, 14'd11000);
      step("r9150", 1'b1, 14'd9150, 1'b0, 1'b1, 14'd11500);
      step("r9200", 1'b1, 14'd9200, 1'b0, 1'b1, 14'd12000);
      check("r9200.busy", 32'(busy), 32'd1);
      step("rho1", 1'b1, 14'd9300, 1'b0, 1'b0, 14'd0);
      check("rho1.busy", 32'(busy), 32'd1);
      step("rho2", 1'b1, 14'd9300, 1'b0, 1'b0, 14'd0);
      check("rho2.busy", 32'(busy), 32'd0);
      step("rarm", 1'b1, 14'd9300, 1'b0, 1'b0, 14'd0);

      // Already above the level: no trigger until a sample at or below 8900.
      do_reset("rst1");
      for (int i = 0; i < 5; i++) step("above", 1'b1, 14'd9500, 1'b0, 1'b0, 14'd0);
      step("rearm8900", 1'b1, 14'd8900, 1'b0, 1'b0, 14'd0);
      step("fire9001", 1'b1, 14'd9001, 1'b1, 1'b1, 14'd10010);

      // Falling SINGLE, post_len 0 (acts as 1), holdoff 0; out_pulse wraps.
      mode        = 2'd1;
      trig_slope  = 1'b0;
      trig_level  = 14'd7000;
      post_len    = 16'd0;
      holdoff_len = 16'd0;
      do_reset("rst2");
      step("s_idle_hi", 1'b1, 14'd7200, 1'b0, 1'b0, 14'd0);
      step("s_idle_lo", 1'b1, 14'd6900, 1'b0, 1'b0, 14'd0);
      pulse_arm();
      step("s1_hi", 1'b1, 14'd7200, 1'b0, 1'b0, 14'd0);
      step("s1_lo", 1'b1, 14'd6900, 1'b1, 1'b1, 14'd5384);
      check("s1.busy", 32'(busy), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step("s1_after_hi", 1'b1, 14'd7200, 1'b0, 1'b0, 14'd0);
         step("s1_after_lo", 1'b1, 14'd6900, 1'b0, 1'b0, 14'd0);
      end
      pulse_arm();
      step("s2_hi", 1'b1, 14'd7200, 1'b0, 1'b0, 14'd0);
      step("s2_lo", 1'b1, 14'd6900, 1'b1, 1'b1, 14'd5384);
      step("s2_after_hi", 1'b1, 14'd7200, 1'b0, 1'b0, 14'd0);
      step("s2_after_lo", 1'b1, 14'd6900, 1'b0, 1'b0, 14'd0);

      // LEVEL mode entered from IDLE without reset: trigger/capture follow fire.
      mode       = 2'd2;
      trig_slope = 1'b1;
      trig_level = 14'd9000;
      for (int i = 0; i < 3; i++) begin
         step("lvl8990", 1'b1, 14'd8990, 1'b0, 1'b0, 14'd0);
         step("lvl9010", 1'b1, 14'd9010, 1'b1, 1'b1, 14'd10100);
         check("lvl.busy", 32'(busy), 32'd0);
      end

      // Sparse valid samples, holdoff 5: crossings inside holdoff are ignored.
      mode        = 2'd0;
      post_len    = 16'd2;
      holdoff_len = 16'd5;
      do_reset("rst3");
      gstep("g_rearm", 14'd8800, 1'b0, 1'b0, 14'd0);
      gstep("g_fire",  14'd9100, 1'b1, 1'b1, 14'd11000);
      gstep("g_cap2",  14'd9100, 1'b0, 1'b1, 14'd11000);
      check("g_cap2.busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         gstep("g_hold", (i % 2 == 0) ? 14'd8800 : 14'd9100, 1'b0, 1'b0, 14'd0);
         check("g_hold.busy", 32'(busy), 32'd1);
      end
      gstep("g_hold_last", 14'd8800, 1'b0, 1'b0, 14'd0);
      check("g_hold_last.busy", 32'(busy), 32'd0);
      gstep("g_no_rearm", 14'd9100, 1'b0, 1'b0, 14'd0);
      gstep("g_rearm2",   14'd8800, 1'b0, 1'b0, 14'd0);
      gstep("g_fire2",    14'd9100, 1'b1, 1'b1, 14'd11000);

      // Reset asserted at capture sample 2 of 4, then a trigger at sample 37.
      post_len    = 16'd4;
      holdoff_len = 16'd2;
      do_reset("rst4");
      step("m_rearm", 1'b1, 14'd8800, 1'b0, 1'b0, 14'd0);
      step("m_fire",  1'b1, 14'd9050, 1'b1, 1'b1, 14'd10500);
      step("m_cap2",  1'b1, 14'd9100, 1'b0, 1'b1, 14'd11000);
      @(negedge clk);
      reset     = 1'b1;
      adc_valid = 1'b0;
      #1;
      check_idle_outputs("m_async");
      @(posedge clk);
      #1;
      check_idle_outputs("m_next");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 37; i++) step("ts_pre", 1'b1, 14'd8800, 1'b0, 1'b0, 14'd0);
      step("ts_fire", 1'b1, 14'd9100, 1'b1, 1'b1, 14'd11000);
      check("ts37", trig_timestamp, exp_ts(32'd37));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
